// File: rtl/mem_stage.sv
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Memory-access pipeline stage; launches loads/stores on a req/ack
//             port, zero-extends load data and stalls upstream while waiting.
//             Optional watchdog: define MEM_STAGE_WATCHDOG_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic [4:0]  Rd,
    input  logic [63:0] ALUResult,
    input  logic [63:0] StoreData,
    input  logic [1:0]  Size,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        stall,
    output logic        RegWrite_out,
    output logic [4:0]  Rd_out,
    output logic [63:0] Data_out,
    output logic        mem_fault
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic [4:0]  rd_q, rd_d;
    logic        regwrite_q, regwrite_d;
    logic        we_q, we_d;

    logic        w_mem_op;
    logic        w_misaligned;
    logic [63:0] w_load_data;

`ifdef MEM_STAGE_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign w_mem_op = valid & (MemRead | MemWrite);

    always_comb begin
        w_misaligned = 1'b0;
        case (Size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = ALUResult[0];
            2'b10:   w_misaligned = |ALUResult[1:0];
            default: w_misaligned = |ALUResult[2:0];
        endcase
    end

    always_comb begin
        w_load_data = 64'd0;
        case (size_q)
            2'b00:   w_load_data = {56'd0, mem_rdata[7:0]};
            2'b01:   w_load_data = {48'd0, mem_rdata[15:0]};
            2'b10:   w_load_data = {32'd0, mem_rdata[31:0]};
            default: w_load_data = mem_rdata;
        endcase
    end

    // Request signals come straight from registered state, so they are glitch-free.
    assign mem_req   = (state_q == S_WAIT);
    assign mem_we    = mem_req & we_q;
    assign stall     = mem_req;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_size  = size_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        rd_d         = rd_q;
        regwrite_d   = regwrite_q;
        we_d         = we_q;
        RegWrite_out = 1'b0;
        Rd_out       = 5'd0;
        Data_out     = 64'd0;
        mem_fault    = 1'b0;
`ifdef MEM_STAGE_WATCHDOG_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_mem_op) begin
                    if (w_misaligned) begin
                        mem_fault = 1'b1;
                    end else begin
                        addr_d     = ALUResult;
                        wdata_d    = StoreData;
                        size_d     = Size;
                        rd_d       = Rd;
                        regwrite_d = RegWrite;
                        we_d       = ~MemRead;   // a load wins when both flags are set
                        state_d    = S_WAIT;
`ifdef MEM_STAGE_WATCHDOG_EN
                        cnt_d      = '0;
`endif
                    end
                end else if (valid) begin
                    RegWrite_out = RegWrite;
                    Rd_out       = Rd;
                    Data_out     = ALUResult;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    RegWrite_out = regwrite_q;
                    Rd_out       = rd_q;
                    Data_out     = we_q ? 64'd0 : w_load_data;
                    state_d      = S_IDLE;
                end else begin
`ifdef MEM_STAGE_WATCHDOG_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_fault = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            size_q     <= 2'd0;
            rd_q       <= 5'd0;
            regwrite_q <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            we_q       <= we_d;
        end
    end

`ifdef MEM_STAGE_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Scoreboard bench for mem_stage; directed vectors, MEM/WB results
//             compared by an independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid, MemRead, MemWrite, RegWrite;
    logic [4:0]  Rd;
    logic [63:0] ALUResult, StoreData;
    logic [1:0]  Size;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        stall, RegWrite_out, mem_fault;
    logic [4:0]  Rd_out;
    logic [63:0] Data_out;

    localparam logic [63:0] c_RDATA = 64'hFFEE_DDCC_BBAA_9988;

    typedef struct {
        logic        fault;
        logic        rw;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .valid(valid), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .Rd(Rd), .ALUResult(ALUResult),
        .StoreData(StoreData), .Size(Size), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
        .RegWrite_out(RegWrite_out), .Rd_out(Rd_out), .Data_out(Data_out),
        .mem_fault(mem_fault)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
        Rd = 5'd0; ALUResult = 64'd0; StoreData = 64'd0; Size = 2'd0;
    endtask

    // Monitor: pops an expectation whenever the stage hands a result or a fault to MEM/WB.
    always @(negedge clk) begin
        if (!reset && ((stall && mem_ack) || mem_fault ||
                       (!stall && valid && !MemRead && !MemWrite))) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: rw=%0b rd=%0d data=0x%0h fault=%0b",
                         RegWrite_out, Rd_out, Data_out, mem_fault);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_fault", {63'd0, mem_fault}, {63'd0, e.fault});
                chk("sb_regwrite", {63'd0, RegWrite_out}, {63'd0, e.rw});
                chk("sb_rd", {59'd0, Rd_out}, {59'd0, e.rd});
                chk("sb_data", Data_out, e.data);
            end
        end
    end

    task automatic alu_op(input logic [4:0] rd, input logic [63:0] res);
        valid = 1'b1; RegWrite = 1'b1; Rd = rd; ALUResult = res;
        q.push_back('{1'b0, 1'b1, rd, res});
        @(negedge clk);
        chk("alu_stall", {63'd0, stall}, 64'd0);
        chk("alu_req", {63'd0, mem_req}, 64'd0);
        tick;
        idle_inputs();
    endtask

    task automatic mem_op(input logic rd_en, input logic wr_en, input logic rw,
                          input logic [4:0] rd, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [1:0] sz,
                          input int nwait, input logic [63:0] rdata,
                          input logic [63:0] exp);
        valid = 1'b1; MemRead = rd_en; MemWrite = wr_en; RegWrite = rw;
        Rd = rd; ALUResult = addr; StoreData = wdata; Size = sz;
        q.push_back('{1'b0, rw, rd, exp});
        @(negedge clk);
        chk("accept_stall", {63'd0, stall}, 64'd0);
        chk("accept_req", {63'd0, mem_req}, 64'd0);
        chk("accept_bubble", {63'd0, RegWrite_out} | Data_out, 64'd0);
        tick;
        idle_inputs();
        for (int k = 1; k <= nwait; k++) begin
            if (k == nwait) begin
                mem_ack = 1'b1;
                mem_rdata = rdata;
            end
            @(negedge clk);
            chk("wait_stall", {63'd0, stall}, 64'd1);
            chk("wait_req", {63'd0, mem_req}, 64'd1);
            chk("wait_we", {63'd0, mem_we}, {63'd0, wr_en & ~rd_en});
            chk("wait_addr", mem_addr, addr);
            chk("wait_wdata", mem_wdata, wdata);
            chk("wait_size", {62'd0, mem_size}, {62'd0, sz});
            if (k < nwait) chk("wait_bubble", {63'd0, RegWrite_out} | Data_out, 64'd0);
            tick;
            mem_ack = 1'b0;
            mem_rdata = 64'd0;
        end
        @(negedge clk);
        chk("done_stall", {63'd0, stall}, 64'd0);
        chk("done_req", {63'd0, mem_req}, 64'd0);
        tick;
    endtask

    task automatic bad_align(input logic [63:0] addr, input logic [1:0] sz);
        valid = 1'b1; MemRead = 1'b1; RegWrite = 1'b1; Rd = 5'd4;
        ALUResult = addr; Size = sz;
        q.push_back('{1'b1, 1'b0, 5'd0, 64'd0});
        @(negedge clk);
        chk("mis_stall", {63'd0, stall}, 64'd0);
        chk("mis_req", {63'd0, mem_req}, 64'd0);
        tick;
        idle_inputs();
        @(negedge clk);
        chk("mis_req_after", {63'd0, mem_req}, 64'd0);
        chk("mis_fault_once", {63'd0, mem_fault}, 64'd0);
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        mem_ack = 1'b0;
        mem_rdata = 64'd0;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_outputs", {mem_req, mem_we, stall, mem_fault, RegWrite_out, Rd_out, mem_size}, 64'd0);
        chk("rst_addr", mem_addr | mem_wdata | Data_out, 64'd0);
        tick;

        alu_op(5'd5, 64'h1234);
        mem_op(1'b1, 1'b0, 1'b1, 5'd7,  64'h103, 64'h0,        2'b00, 3, c_RDATA, 64'h88);
        mem_op(1'b1, 1'b0, 1'b1, 5'd9,  64'h40,  64'h0,        2'b10, 1, c_RDATA, 64'hBBAA_9988);
        mem_op(1'b0, 1'b1, 1'b0, 5'd0,  64'h200, 64'hDEADBEEF, 2'b11, 2, 64'h5555, 64'h0);
        mem_op(1'b1, 1'b0, 1'b1, 5'd3,  64'h6,   64'h0,        2'b01, 1, c_RDATA, 64'h9988);
        mem_op(1'b1, 1'b0, 1'b1, 5'd31, 64'h8,   64'h77,       2'b11, 2, c_RDATA, c_RDATA);
        mem_op(1'b1, 1'b1, 1'b1, 5'd2,  64'h44,  64'h99,       2'b10, 1, c_RDATA, 64'hBBAA_9988);
        bad_align(64'h104, 2'b11);
        bad_align(64'h1, 2'b01);

        // Stray ack while idle must not produce a result or enter WAIT.
        mem_ack = 1'b1;
        mem_rdata = c_RDATA;
        @(negedge clk);
        chk("idle_ack_out", {63'd0, RegWrite_out} | Data_out, 64'd0);
        chk("idle_ack_stall", {63'd0, stall}, 64'd0);
        tick;
        mem_ack = 1'b0;
        mem_rdata = 64'd0;
        @(negedge clk);
        chk("idle_ack_req", {63'd0, mem_req}, 64'd0);
        tick;

`ifdef MEM_STAGE_WATCHDOG_EN
        valid = 1'b1; MemRead = 1'b1; RegWrite = 1'b1; Rd = 5'd6;
        ALUResult = 64'h80; Size = 2'b11;
        tick;
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) q.push_back('{1'b1, 1'b0, 5'd0, 64'd0});
            @(negedge clk);
            chk("wd_stall", {63'd0, stall}, 64'd1);
            chk("wd_fault", {63'd0, mem_fault}, {63'd0, k == 4});
            tick;
        end
        @(negedge clk);
        chk("wd_req_drop", {63'd0, mem_req}, 64'd0);
        tick;
`endif

        // Reset in the second WAIT cycle abandons the access.
        valid = 1'b1; MemRead = 1'b1; RegWrite = 1'b1; Rd = 5'd12;
        ALUResult = 64'h300; StoreData = 64'hAB; Size = 2'b10;
        tick;
        idle_inputs();
        tick;
        @(negedge clk);
        chk("rw_in_wait", {63'd0, mem_req}, 64'd1);
        reset = 1'b1;
        tick;
        @(negedge clk);
        chk("rw_outputs", {mem_req, mem_we, stall, mem_fault, RegWrite_out, Rd_out, mem_size}, 64'd0);
        chk("rw_addr", mem_addr | mem_wdata | Data_out, 64'd0);
        reset = 1'b0;
        tick;

        alu_op(5'd17, 64'hCAFE);
        tick;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected results never seen, required 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
